timer_block: RTL and testbench

- Programmable timer that consumes the control fields of the peripheral register file: rf_trig_start, rf_trig_halt, rf_mode and rf_termcount.
- Returns ro_status and ro_currcount to the register file for software readback.
- Raises a one-cycle terminal-count pulse toward the interrupt logic.
- Supports one-shot and auto-reload counting, with an optional clock prescaler.

---
 rtl/timer_block.sv | 106 ++++++++++
 tb/tb_timer_block.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_block.sv
// Programmable timer driven by the peripheral register file: one-shot or auto-reload
// counting with a clock prescaler, status/count readback and a one-cycle terminal pulse.
module timer_block #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rf_trig_start,
    input  logic        rf_trig_halt,
    input  logic        rf_mode,
    input  logic [31:0] rf_termcount,
    output logic        ro_status,
    output logic [31:0] ro_currcount,
    output logic        tc_pulse
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_count, w_count_nxt;
    logic [15:0] r_presc, w_presc_nxt;
    logic        r_tc, w_tc_nxt;
    logic        r_status;
    logic        r_start_q, r_halt_q;
    logic        w_start_edge, w_halt_edge, w_tick;

    assign w_start_edge = rf_trig_start & ~r_start_q;
    assign w_halt_edge  = rf_trig_halt  & ~r_halt_q;
    assign w_tick       = (r_state == S_RUN) && (r_presc == PRESC_LAST);

    // NOTE: every register here is updated with <= so all flops sample the same
    // pre-edge values; blocking assignments would make the result order-dependent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 32'd0;
            r_presc   <= 16'd0;
            r_tc      <= 1'b0;
            r_status  <= 1'b0;
            r_start_q <= 1'b0;
            r_halt_q  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_presc   <= w_presc_nxt;
            r_tc      <= w_tc_nxt;
            r_status  <= (w_state_nxt == S_RUN);
            r_start_q <= rf_trig_start;
            r_halt_q  <= rf_trig_halt;
        end
    end

    // NOTE: each signal is given its hold value first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_tc_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A coincident halt edge suppresses the start.
                if (w_start_edge && !w_halt_edge) begin
                    w_state_nxt = S_RUN;
                    w_count_nxt = 32'd0;
                    w_presc_nxt = 16'd0;
                end
            end
            S_RUN: begin
                if (w_halt_edge) begin
                    w_state_nxt = S_IDLE;
                end else if (w_start_edge) begin
                    w_count_nxt = 32'd0;
                    w_presc_nxt = 16'd0;
                end else begin
                    w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;
                    if (w_tick) begin
                        // >= rather than == so a lowered terminal value still ends the period.
                        if (r_count >= rf_termcount) begin
                            w_tc_nxt = 1'b1;
                            if (rf_mode) begin
                                w_count_nxt = 32'd0;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end else begin
                            w_count_nxt = r_count + 32'd1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ro_status    = r_status;
    assign ro_currcount = r_count;
    assign tc_pulse     = r_tc;

endmodule

// File: tb/tb_timer_block.sv
// Self-checking bench for timer_block: two instances (PRESCALE 1 and 4) share directed
// stimulus and are compared every cycle against a cycle-counting behavioural model.
module tb_timer_block;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] term = 32'd0;

    logic        st1, tc1, st4, tc4;
    logic [31:0] cnt1, cnt4;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    timer_block #(.PRESCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .rf_trig_start(start), .rf_trig_halt(halt),
        .rf_mode(mode), .rf_termcount(term),
        .ro_status(st1), .ro_currcount(cnt1), .tc_pulse(tc1)
    );

    timer_block #(.PRESCALE(4)) u_dut4 (
        .clk(clk), .reset(reset), .rf_trig_start(start), .rf_trig_halt(halt),
        .rf_mode(mode), .rf_termcount(term),
        .ro_status(st4), .ro_currcount(cnt4), .tc_pulse(tc4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: running flag, count, and clk cycles elapsed since the last tick.
    bit     m_run [2];
    longint m_cnt [2];
    int     m_div [2];
    bit     m_tc  [2];
    bit     p_start, p_halt;

    function automatic int presc_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    always @(posedge clk) begin
        bit se, he;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 1'b0; m_cnt[k] = 0; m_div[k] = 0; m_tc[k] = 1'b0;
            end
            p_start = 1'b0;
            p_halt  = 1'b0;
        end else begin
            se = start && !p_start;
            he = halt && !p_halt;
            for (int k = 0; k < 2; k++) begin
                m_tc[k] = 1'b0;
                if (he) begin
                    m_run[k] = 1'b0;
                end else if (se) begin
                    m_run[k] = 1'b1; m_cnt[k] = 0; m_div[k] = 0;
                end else if (m_run[k]) begin
                    m_div[k]++;
                    if (m_div[k] == presc_of(k)) begin
                        m_div[k] = 0;
                        if (m_cnt[k] >= longint'(term)) begin
                            m_tc[k] = 1'b1;
                            if (mode) m_cnt[k] = 0;
                            else      m_run[k] = 1'b0;
                        end else begin
                            m_cnt[k]++;
                        end
                    end
                end
            end
            p_start = start;
            p_halt  = halt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_status1", {31'd0, st1}, {31'd0, m_run[0]});
            check("model_count1",  cnt1,         m_cnt[0][31:0]);
            check("model_tc1",     {31'd0, tc1}, {31'd0, m_tc[0]});
            check("model_status4", {31'd0, st4}, {31'd0, m_run[1]});
            check("model_count4",  cnt4,         m_cnt[1][31:0]);
            check("model_tc4",     {31'd0, tc4}, {31'd0, m_tc[1]});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_status", {31'd0, st1}, 32'd0);
        check("rst_count",  cnt1,         32'd0);
        check("rst_tc",     {31'd0, tc1}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // One-shot, termcount 3, PRESCALE 1
        term = 32'd3; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        check("os_status_rise", {31'd0, st1}, 32'd1);
        check("os_count0",      cnt1,         32'd0);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("os_count", cnt1, 32'(i));
            check("os_no_tc", {31'd0, tc1}, 32'd0);
        end
        @(negedge clk);
        check("os_tc",        {31'd0, tc1}, 32'd1);
        check("os_status_lo", {31'd0, st1}, 32'd0);
        check("os_hold",      cnt1,         32'd3);
        @(negedge clk);
        check("os_tc_once",   {31'd0, tc1}, 32'd0);
        check("os_hold2",     cnt1,         32'd3);

        // Auto-reload, termcount 4: three periods of 5 cycles
        term = 32'd4; mode = 1'b1; start = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            check("ar_count",  cnt1,         32'(i % 5));
            check("ar_tc",     {31'd0, tc1}, {31'd0, (i >= 5) && (i % 5 == 0)});
            check("ar_status", {31'd0, st1}, 32'd1);
        end
        halt = 1'b1;
        @(negedge clk);
        check("ar_halted", {31'd0, st1}, 32'd0);
        halt = 1'b0;
        @(negedge clk);

        // PRESCALE 4, one-shot, termcount 2: terminal 12 clks after RUN entry
        term = 32'd2; mode = 1'b0; start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            check("ps_count",  cnt4,         32'(k / 4));
            check("ps_status", {31'd0, st4}, 32'd1);
            check("ps_no_tc",  {31'd0, tc4}, 32'd0);
        end
        @(negedge clk);
        check("ps_tc",        {31'd0, tc4}, 32'd1);
        check("ps_status_lo", {31'd0, st4}, 32'd0);
        check("ps_hold",      cnt4,         32'd2);
        @(negedge clk);
        check("ps_tc_once",   {31'd0, tc4}, 32'd0);

        // Halt at count 7, then restart
        term = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hl_count0", cnt1, 32'd0);
        repeat (7) @(negedge clk);
        check("hl_count7", cnt1, 32'd7);
        halt = 1'b1;
        @(negedge clk);
        check("hl_status", {31'd0, st1}, 32'd0);
        check("hl_hold",   cnt1,         32'd7);
        check("hl_no_tc",  {31'd0, tc1}, 32'd0);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        check("hl_hold_late", cnt1, 32'd7);
        start = 1'b1;
        @(negedge clk);
        check("rs_status", {31'd0, st1}, 32'd1);
        check("rs_count0", cnt1,         32'd0);
        start = 1'b0;
        @(negedge clk);
        check("rs_count1", cnt1, 32'd1);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        @(negedge clk);

        // Simultaneous start and halt in IDLE: halt wins
        start = 1'b1; halt = 1'b1;
        @(negedge clk);
        check("sh_status1", {31'd0, st1}, 32'd0);
        check("sh_status4", {31'd0, st4}, 32'd0);
        start = 1'b0; halt = 1'b0;
        @(negedge clk);

        // Start held high for 20 cycles: a single start, count never restarts
        term = 32'd1000; start = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_count",  cnt1,         32'd19);
        check("hold_status", {31'd0, st1}, 32'd1);
        start = 1'b0; halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        @(negedge clk);

        // termcount 0 in auto-reload: terminal on every tick
        term = 32'd0; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t0_count", cnt1,         32'd0);
        check("t0_no_tc", {31'd0, tc1}, 32'd0);
        @(negedge clk);
        check("t0_tc_a",  {31'd0, tc1}, 32'd1);
        check("t0_cnt_a", cnt1,         32'd0);
        @(negedge clk);
        check("t0_tc_b",  {31'd0, tc1}, 32'd1);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        @(negedge clk);

        // Lowering termcount below the current count fires on the next tick
        mode = 1'b0; term = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("lw_count50", cnt1, 32'd50);
        term = 32'd10;
        @(negedge clk);
        check("lw_tc",     {31'd0, tc1}, 32'd1);
        check("lw_status", {31'd0, st1}, 32'd0);
        check("lw_hold",   cnt1,         32'd50);
        @(negedge clk);

        // Reset mid-run aborts immediately
        term = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mr_count5", cnt1,         32'd5);
        check("mr_status", {31'd0, st1}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_rst_count",  cnt1,         32'd0);
        check("mr_rst_status", {31'd0, st1}, 32'd0);
        check("mr_rst_tc",     {31'd0, tc1}, 32'd0);
        check("mr_rst_count4", cnt4,         32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mr_idle", {31'd0, st1}, 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
